// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus arbiter: address map, FSM states and
// slave-select codes.
package dbus_pkg;

  localparam logic [31:0] DM_HI    = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_LO  = 32'h0000_7F00;
  localparam logic [31:0] TMR0_HI  = 32'h0000_7F0B;
  localparam logic [31:0] TMR1_LO  = 32'h0000_7F10;
  localparam logic [31:0] TMR1_HI  = 32'h0000_7F1B;
  localparam logic [31:0] IG_LO    = 32'h0000_7F20;
  localparam logic [31:0] IG_HI    = 32'h0000_7F23;
  localparam logic [31:0] TMR0_CNT = 32'h0000_7F08;
  localparam logic [31:0] TMR1_CNT = 32'h0000_7F18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_DM    = 2'd0,
    SEL_TIMER = 2'd1,
    SEL_IG    = 2'd2,
    SEL_NONE  = 2'd3
  } slave_t;

endpackage

// File: rtl/dbus_decode.sv
// Address decoder: maps a byte address and direction onto a slave select.
// Unmapped addresses and writes to a timer count word decode to SEL_NONE.
module dbus_decode
  import dbus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output slave_t            sel,
  output logic              err
);

  logic [ADDR_W-1:0] word_addr;
  logic              cnt_word;
  logic              in_timer;

  always_comb begin
    word_addr = {addr[ADDR_W-1:2], 2'b00};
    cnt_word  = (word_addr == ADDR_W'(TMR0_CNT)) || (word_addr == ADDR_W'(TMR1_CNT));
    in_timer  = ((addr >= ADDR_W'(TMR0_LO)) && (addr <= ADDR_W'(TMR0_HI))) ||
                ((addr >= ADDR_W'(TMR1_LO)) && (addr <= ADDR_W'(TMR1_HI)));
    sel = SEL_NONE;
    if (addr <= ADDR_W'(DM_HI)) begin
      sel = SEL_DM;
    end else if (in_timer) begin
      // Timer count words are read-only.
      sel = (we && cnt_word) ? SEL_NONE : SEL_TIMER;
    end else if ((addr >= ADDR_W'(IG_LO)) && (addr <= ADDR_W'(IG_HI))) begin
      sel = SEL_IG;
    end
    err = (sel == SEL_NONE);
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant, one-cycle slave strobe,
// single-cycle ack. Handshake: mN_req is held with stable fields until mN_ack.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_byteen,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_stall,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_byteen,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W/8-1:0] dm_byteen,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic [ADDR_W-1:0]   dev_addr,
  output logic [DATA_W-1:0]   dev_wdata,
  output logic [DATA_W/8-1:0] dev_byteen,
  input  logic [DATA_W-1:0]   dev_rdata,
  output logic [DATA_W/8-1:0] ig_byteen,
  output logic [1:0]          dbg_state
);

  localparam int BE_W = DATA_W / 8;

  state_t              state, state_nxt;
  logic                last;
  logic                grant;
  logic                grant_nxt;
  logic                any_req;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;
  slave_t              lat_sel;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [BE_W-1:0]     req_be;
  slave_t              dec_sel;
  logic                dec_err;
  logic [DATA_W-1:0]   resp_rdata;

  // On a tie the master not granted last wins.
  assign any_req   = m0_req || m1_req;
  assign grant_nxt = (m0_req && m1_req) ? ~last : m1_req;
  assign req_we    = grant_nxt ? m1_we     : m0_we;
  assign req_addr  = grant_nxt ? m1_addr   : m0_addr;
  assign req_wdata = grant_nxt ? m1_wdata  : m0_wdata;
  assign req_be    = grant_nxt ? m1_byteen : m0_byteen;

  dbus_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr (req_addr),
    .we   (req_we),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      grant     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_sel   <= SEL_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        grant     <= grant_nxt;
        last      <= grant_nxt;
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_sel   <= dec_sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_byteen  = '0;
    dev_addr   = '0;
    dev_wdata  = '0;
    dev_byteen = '0;
    ig_byteen  = '0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_rdata   = '0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_rdata   = '0;
    resp_rdata = '0;
    if (state == ST_ACCESS) begin
      case (lat_sel)
        SEL_DM: begin
          dm_addr   = lat_addr;
          dm_wdata  = lat_wdata;
          dm_byteen = lat_we ? lat_be : '0;
        end
        SEL_TIMER: begin
          dev_addr   = lat_addr;
          dev_wdata  = lat_wdata;
          dev_byteen = lat_we ? lat_be : '0;
        end
        SEL_IG:  ig_byteen = lat_we ? lat_be : '0;
        default: ;
      endcase
    end
    if (state == ST_RESP) begin
      // The interrupt generator has no read port; its reads return zero.
      if (!lat_we) begin
        case (lat_sel)
          SEL_DM:    resp_rdata = dm_rdata;
          SEL_TIMER: resp_rdata = dev_rdata;
          default:   resp_rdata = '0;
        endcase
      end
      if (grant) begin
        m1_ack   = 1'b1;
        m1_err   = (lat_sel == SEL_NONE);
        m1_rdata = resp_rdata;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = (lat_sel == SEL_NONE);
        m0_rdata = resp_rdata;
      end
    end
  end

  assign m0_stall  = m0_req && !m0_ack;
  assign dbg_state = state;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: vector table for single transfers,
// hand-written sequences for arbitration and mid-transaction reset.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dm_byteen, dev_byteen, ig_byteen;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  logic [33:0] exp_q[$];
  logic [33:0] mon_act, mon_exp;

  typedef struct {
    logic        master;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] srd;
    logic [1:0]  sel;   // 0 DM, 1 timer port, 2 IG, 3 none
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[15];

  dbus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_byteen(m0_byteen), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_byteen(m1_byteen), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_byteen(dev_byteen),
    .dev_rdata(dev_rdata), .ig_byteen(ig_byteen), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_m(input logic m, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (m) begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = wd; m1_byteen = be;
    end else begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = wd; m0_byteen = be;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acks"}, {m0_ack, m0_err, m1_ack, m1_err, m0_stall}, 0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 0);
    check({tag, "_dm"}, {dm_addr, dm_wdata}, 0);
    check({tag, "_dev"}, {dev_addr, dev_wdata}, 0);
    check({tag, "_be"}, {dm_byteen, dev_byteen, ig_byteen}, 0);
  endtask

  // Scoreboard: each ack pops the oldest expected {master, err, rdata}.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      mon_act = m1_ack ? {1'b1, m1_err, m1_rdata} : {1'b0, m0_err, m0_rdata};
      if (m0_ack && m1_ack) begin
        checks++; failures++;
        $display("FAIL dual_ack actual=11 required=one");
      end
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual=%0h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_resp", mon_act, mon_exp);
      end
      ack_seen++;
    end
  end

  // Driver for one table transfer, fixed-latency strobe checks.
  task automatic run_vec(input int idx, input vec_t v);
    int target;
    int waited;
    @(negedge clk);
    dm_rdata  = (v.sel == 2'd1) ? ~v.srd : v.srd;
    dev_rdata = (v.sel == 2'd0) ? ~v.srd : v.srd;
    target = ack_seen + 1;
    exp_q.push_back({v.master, v.err, v.rdata});
    drive_m(v.master, 1'b1, v.we, v.addr, v.wdata, v.be);
    @(negedge clk);
    check($sformatf("v%0d_dm_addr", idx), dm_addr, (v.sel == 2'd0) ? v.addr : 32'h0);
    check($sformatf("v%0d_dm_wdata", idx), dm_wdata, (v.sel == 2'd0) ? v.wdata : 32'h0);
    check($sformatf("v%0d_dm_be", idx), dm_byteen, (v.sel == 2'd0 && v.we) ? v.be : 4'h0);
    check($sformatf("v%0d_dev_addr", idx), dev_addr, (v.sel == 2'd1) ? v.addr : 32'h0);
    check($sformatf("v%0d_dev_wdata", idx), dev_wdata, (v.sel == 2'd1) ? v.wdata : 32'h0);
    check($sformatf("v%0d_dev_be", idx), dev_byteen, (v.sel == 2'd1 && v.we) ? v.be : 4'h0);
    check($sformatf("v%0d_ig_be", idx), ig_byteen, (v.sel == 2'd2 && v.we) ? v.be : 4'h0);
    check($sformatf("v%0d_stall_access", idx), m0_stall, !v.master);
    @(negedge clk);
    check($sformatf("v%0d_strobes_resp", idx),
          {dm_byteen, dev_byteen, ig_byteen, dm_addr, dev_addr}, 0);
    check($sformatf("v%0d_stall_ack", idx), m0_stall, 0);
    #1;
    waited = 0;
    while (ack_seen < target && waited < 6) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check($sformatf("v%0d_ack_timeout", idx), ack_seen >= target, 1);
    drive_m(v.master, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678, 2'd0, 1'b0, 32'h1234_5678};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_7F04, 32'hAABB_CCDD, 4'h3, 32'h0,         2'd1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_7F08, 32'h1111_2222, 4'hF, 32'h0,         2'd3, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'h0, 32'h5555_AAAA, 2'd3, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_2FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 2'd0, 1'b0, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,         4'h0, 32'h7777_7777, 2'd3, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_7F18, 32'h0,         4'h0, 32'h0000_0055, 2'd1, 1'b0, 32'h0000_0055};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_7F18, 32'h3333_4444, 4'hF, 32'h0,         2'd3, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_7F20, 32'h0000_00FF, 4'hF, 32'h0,         2'd2, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_7F0C, 32'h0,         4'h0, 32'h9999_0000, 2'd3, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_7F1B, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'd1, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_7F24, 32'h0,         4'h0, 32'h1357_9BDF, 2'd3, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0102_0304, 4'hC, 32'h0,         2'd0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_7F20, 32'h0,         4'h0, 32'h2468_ACE0, 2'd2, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0001_0010, 32'h0,         4'h0, 32'h0F0F_0F0F, 2'd3, 1'b1, 32'h0};

    reset = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dm_rdata  = 32'h0;
    dev_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check_all_zero("rst");
    reset = 1'b1;

    // Both masters from reset: m0, then m1, then m0 again (held request).
    @(negedge clk);
    dm_rdata = 32'h0BAD_CAFE;
    drive_m(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive_m(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_CAFE});
    exp_q.push_back({1'b1, 1'b0, 32'h0BAD_CAFE});
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_CAFE});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("rr_m0_ack_c%0d", c), m0_ack, (c == 2 || c == 8));
      check($sformatf("rr_m1_ack_c%0d", c), m1_ack, (c == 5));
      check($sformatf("rr_m0_stall_c%0d", c), m0_stall, (c != 2 && c != 8 && c != 9));
      if (c == 5) m1_req = 1'b0;
      if (c == 8) m0_req = 1'b0;
    end

    // Reset in ACCESS of an m1 write to the interrupt generator.
    @(negedge clk);
    drive_m(1'b1, 1'b1, 1'b1, 32'h7F20, 32'h0000_00FF, 4'hF);
    @(negedge clk);
    check("rstmid_ig_be_access", ig_byteen, 4'hF);
    reset  = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    check("rstmid_state", dbg_state, 2'd0);
    check_all_zero("rstmid");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_ack", m1_ack, 0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("final_idle", dbg_state, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Data-bus arbiter and sequencer between two masters and the system's memory-mapped slaves. Masters: the CPU memory-stage port (m0) and a DMA/debug port (m1). Slaves: data memory (DM), the two timers on a shared device port, and the interrupt generator. The block grants one master at a time with round-robin fairness, decodes the address, drives slave strobes for exactly one cycle, registers read data, and returns a single-cycle ack. It sits between the pipeline's memory stage and the bridge/slave layer.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk` input 1 system clock
- `reset` input 1 synchronous, active-low reset (`reset==0` at a rising edge resets)
- `mN_req` input 1 master N (N=0,1) request; held high with stable fields until `mN_ack`
- `mN_we` input 1 1 = write
- `mN_addr` input 32 byte address
- `mN_wdata` input 32 write data, already lane-aligned
- `mN_byteen` input 4 byte lanes; nonzero for writes, ignored for reads
- `mN_ack` output 1 one-cycle completion pulse
- `mN_err` output 1 valid with ack; access rejected
- `mN_rdata` output 32 valid with ack; raw 32-bit word, 0 on write or error
- `m0_stall` output 1 `m0_req && !m0_ack`, combinational pipeline freeze
- `dm_addr`, `dm_wdata` output 32 DM address and data
- `dm_byteen` output 4 DM write lanes, nonzero only in ACCESS
- `dm_rdata` input 32 DM read word, valid the cycle after ACCESS
- `dev_addr`, `dev_wdata` output 32 timer port address and data
- `dev_byteen` output 4 timer write lanes
- `dev_rdata` input 32 timer read word, valid the cycle after ACCESS
- `ig_byteen` output 4 interrupt-generator write lanes, nonzero only in ACCESS

## Operation
- Address map: DM 0x0000–0x2FFF; timer0 0x7F00–0x7F0B; timer1 0x7F10–0x7F1B; interrupt generator word 0x7F20–0x7F23.
- Anything else is an error. A write to a timer count word (word address 0x7F08 or 0x7F18) is also an error.
- Erroneous accesses drive no strobes, return `err=1` and `rdata=0`, and use the same timing as a good access.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any `req` is high. The grant is latched, along with `we`, `addr`, `wdata`, `byteen` and the decoded slave.
  - ACCESS → RESP unconditionally. In ACCESS the selected slave's address, wdata and byteen are driven (byteen only if `we`).
  - RESP → IDLE unconditionally. In RESP, `ack` pulses to the granted master and `rdata` is taken from the selected slave's read port.
- Arbitration: if only one master requests, it wins. If both request in IDLE, the winner is the master not granted last; the `last` register updates on every grant.
- The address outputs of unselected slaves hold 0. `dev_addr` is driven for both timers; the slave decodes bit 4.
- Master request changes while not granted are legal and are not latched.

## Timing
- Reset values: state IDLE, `last`=1 (so m0 wins the first tie), every output 0 (including `ack`, `err`, `rdata`, all addresses, data and byteen).
- Fixed latency: `req` sampled in IDLE at edge t → ACCESS in cycle t+1 → ack in cycle t+2. Minimum 3 cycles per transaction.
- Back-to-back: a master holding `req` high after its ack is sampled again in the following IDLE cycle. If the other master is also requesting, it wins.
- Reset asserted in ACCESS or RESP: return to IDLE at that edge, no ack issued, strobes low from that edge, and the latched transaction is discarded.
- `m0_stall` is high from the first cycle of `m0_req` through the cycle before `m0_ack`, and low in the ack cycle.

## Structure
- Package `dbus_pkg` holds:
  - address-range constants;
  - the state enum (IDLE/ACCESS/RESP);
  - the slave-select enum (DM, TIMER, IG, NONE).
- One natural sub-module, `dbus_decode`: combinational; takes addr and we, returns slave select and err.
- Top level holds the FSM, the round-robin register, the transaction latch and the response mux.

## Test plan
- m0 read of 0x0000_0010, DM returns 0x1234_5678 → `dm_addr`=0x10 in cycle t+1, `m0_ack`=1, `m0_rdata`=0x1234_5678 and `err`=0 in cycle t+2. `m0_stall` is high in t and t+1.
- m1 write 0xAABB_CCDD, byteen 4'b0011, to 0x7F04 → `dev_byteen`=0011 and `dev_wdata`=0xAABB_CCDD for exactly one cycle; `dm_byteen` and `ig_byteen` stay 0.
- m0 and m1 both request from reset → m0 acked first; m1 acked 3 cycles later; m0 held high is then served after m1 (alternation).
- m0 store to 0x7F08, then m1 load from 0x0000_4000 → both acked with `err`=1 and `rdata`=0; no byteen asserted anywhere.
- `reset`=0 during ACCESS of an m1 write to 0x7F20 → no `m1_ack`. `ig_byteen` falls at that edge. All outputs are 0 and the FSM is in IDLE the next cycle.
